// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the EC413 single-issue core.
//
// Owns the program counter and drives it straight onto the IMem address. The
// word IMem returns in the same cycle is latched into the instruction register
// (ir) together with the address it came from (ir_pc). Decode back-pressure
// (stall) freezes the fetch stage. An execute-stage redirect reloads the PC and
// squashes the word already sitting in ir.
//
// Update priority at every rising edge of clk:
//   rst > redirect_valid > stall > normal fetch
//
// FSM encoding (visible on fetch_state for debug):
//   RUN   = 2'b00  streaming, one instruction per cycle
//   HOLD  = 2'b01  frozen by stall; the next unstalled edge fetches normally
//   FLUSH = 2'b10  one cycle spent presenting the redirect target on imem_pc
//   2'b11 is unreachable. If it ever appears, the next edge returns to RUN and
//   every other register holds, unless a redirect arrives on that edge.
//
// Optional build macro: FETCH_JUMP_PREDECODE_EN
//   When defined, an unconditional jump (opcode imem_instr[31:26] == 6'b000001)
//   is resolved at fetch. The PC loads the jump's low address bits instead of
//   pc+1. The jump is still delivered to decode as a valid instruction, with no
//   bubble. When undefined, a jump is an ordinary word and execute must redirect.
//   The port list is the same in both builds.

module fetch_sequencer #(
  parameter int unsigned          PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter logic [31:0]          NOP_WORD = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_pc,
  input  logic [31:0]         imem_instr,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic [31:0]         ir,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                ir_valid,
  output logic [1:0]          fetch_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HOLD    = 2'b01,
    ST_FLUSH   = 2'b10,
    ST_ILLEGAL = 2'b11
  } fetch_state_e;

  // Opcode of the unconditional jump that the optional predecoder recognises.
  localparam logic [5:0] JUMP_OPCODE = 6'b000001;

  // Architectural state.
  logic [PC_WIDTH-1:0] pc_q,       pc_d;
  logic [31:0]         ir_q,       ir_d;
  logic [PC_WIDTH-1:0] ir_pc_q,    ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  fetch_state_e        state_q,    state_d;

  // Sequential PC. Arithmetic is modulo 2^PC_WIDTH, so the top address wraps
  // to zero silently.
  logic [PC_WIDTH-1:0] pc_plus_one;
  // Next PC used by a normal fetch. This is pc+1, or the jump target when
  // predecode is built in.
  logic [PC_WIDTH-1:0] fetch_next_pc;
  // Set when the current IMem word is a jump that fetch resolves itself.
  logic                is_jump;

  // The PC drives the IMem address directly, so IMem sees no extra latency.
  assign imem_pc     = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign fetch_state = state_q;

  assign pc_plus_one = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Pick the PC that follows a normal fetch of the current IMem word.
  always_comb begin
    is_jump       = 1'b0;
    fetch_next_pc = pc_plus_one;
`ifdef FETCH_JUMP_PREDECODE_EN
    is_jump = (imem_instr[31:26] == JUMP_OPCODE);
    if (is_jump) begin
      fetch_next_pc = imem_instr[PC_WIDTH-1:0];
    end
`else
    // In this build execute resolves jumps through redirect_valid.
    is_jump = 1'b0;
`endif
  end

  // Next-state and datapath selection. Priority is redirect > stall > fetch.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    state_d    = state_q;

    if (redirect_valid) begin
      // Squash the wrong-path word and present the target on IMem for one
      // cycle. A simultaneous stall is ignored.
      pc_d       = redirect_target;
      ir_d       = NOP_WORD;
      ir_valid_d = 1'b0;
      state_d    = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN, ST_HOLD, ST_FLUSH: begin
          if (stall) begin
            // Decode cannot take a word: freeze PC and IR.
            state_d = ST_HOLD;
          end else begin
            ir_d       = imem_instr;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = fetch_next_pc;
            state_d    = ST_RUN;
          end
        end
        default: begin
          // Unreachable encoding: hold everything and resynchronise to RUN.
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State register. Synchronous active-high reset initialises all of the
  // architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      ir_q       <= NOP_WORD;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of fetched words.
module tb_fetch_sequencer;

  localparam int PCW = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [PCW-1:0] imem_pc;
  logic [31:0]    imem_instr;
  logic           stall;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_target;
  logic [31:0]    ir;
  logic [PCW-1:0] ir_pc;
  logic           ir_valid;
  logic [1:0]     fetch_state;

  int checks = 0;
  int errors = 0;

  // Expected {ir, ir_pc} for each word the bench expects the DUT to fetch.
  logic [47:0] sb_q[$];

  // Reference model state.
  logic [PCW-1:0] m_pc;
  logic           m_valid;
  logic [1:0]     m_state;
  logic [31:0]    m_ir;

  fetch_sequencer #(.PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  // IMem model. Each word carries its own address in the low half. Address 26
  // holds a jump to address 0.
  function automatic logic [31:0] imem_word(input logic [PCW-1:0] a);
    if (a == 16'd26) return 32'h0400_0000;
    return {16'hC0DE, a};
  endfunction

  assign imem_instr = imem_word(imem_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one edge, advance the model, then compare the DUT with the model.
  task automatic step(input logic r, input logic s, input logic rv, input logic [PCW-1:0] tgt);
    logic        fetched;
    logic [31:0] w;
    logic [47:0] e;
    fetched = 1'b0;
    rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
    if (r) begin
      m_pc = '0; m_valid = 1'b0; m_state = 2'b00; m_ir = '0;
      sb_q.delete();
    end else if (rv) begin
      m_pc = tgt; m_valid = 1'b0; m_state = 2'b10; m_ir = '0;
    end else if (s) begin
      m_state = 2'b01;
    end else begin
      w = imem_word(m_pc);
      sb_q.push_back({w, m_pc});
      fetched = 1'b1;
      m_ir = w; m_valid = 1'b1; m_state = 2'b00;
`ifdef FETCH_JUMP_PREDECODE_EN
      m_pc = (w[31:26] == 6'b000001) ? w[PCW-1:0] : m_pc + 16'd1;
`else
      m_pc = m_pc + 16'd1;
`endif
    end
    @(posedge clk);
    #1;
    chk("imem_pc", {16'h0, imem_pc}, {16'h0, m_pc});
    chk("ir_valid", {31'h0, ir_valid}, {31'h0, m_valid});
    chk("fetch_state", {30'h0, fetch_state}, {30'h0, m_state});
    chk("ir", ir, m_ir);
    if (fetched) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_ir", ir, e[47:16]);
        chk("sb_ir_pc", {16'h0, ir_pc}, {16'h0, e[15:0]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h1234;
    m_pc = '0; m_valid = 1'b0; m_state = 2'b00; m_ir = '0;
    #1;
    // Reset held for two edges, with stall and redirect both asserted.
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    chk("rst_imem_pc", {16'h0, imem_pc}, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("rst_state", {30'h0, fetch_state}, 32'h0);

    // First edge after reset is released.
    step(1'b0, 1'b0, 1'b0, '0);
    chk("first_ir_pc", {16'h0, ir_pc}, 32'h0);
    chk("first_imem_pc", {16'h0, imem_pc}, 32'h1);
    // Stream four more words, ending with ir_pc=4 and imem_pc=5.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0);
    chk("stream_ir_pc", {16'h0, ir_pc}, 32'h4);

    // Stall for three cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("stall_ir_pc", {16'h0, ir_pc}, 32'h4);
    chk("stall_imem_pc", {16'h0, imem_pc}, 32'h5);
    chk("stall_state", {30'h0, fetch_state}, 32'h1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("unstall_ir_pc", {16'h0, ir_pc}, 32'h5);
    chk("unstall_imem_pc", {16'h0, imem_pc}, 32'h6);
    chk("unstall_state", {30'h0, fetch_state}, 32'h0);

    // Fetch forward until pc=15.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0, '0);
    chk("pre_redir_pc", {16'h0, imem_pc}, 32'd15);
    // Redirect and stall on the same edge: the redirect wins.
    step(1'b0, 1'b1, 1'b1, 16'd17);
    chk("redir_imem_pc", {16'h0, imem_pc}, 32'd17);
    chk("redir_ir", ir, 32'h0);
    chk("redir_state", {30'h0, fetch_state}, 32'h2);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("redir_ir_pc", {16'h0, ir_pc}, 32'd17);
    chk("redir_valid", {31'h0, ir_valid}, 32'h1);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_ir_pc", {16'h0, ir_pc}, 32'hFFFF);
    chk("wrap_imem_pc", {16'h0, imem_pc}, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("wrap_next_ir_pc", {16'h0, ir_pc}, 32'h0);

    // Back-to-back redirects: the later one wins.
    step(1'b0, 1'b0, 1'b1, 16'd40);
    step(1'b0, 1'b0, 1'b1, 16'd50);
    chk("b2b_valid", {31'h0, ir_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("b2b_ir_pc", {16'h0, ir_pc}, 32'd50);

    // A stall during FLUSH moves to HOLD and keeps the squashed IR.
    step(1'b0, 1'b0, 1'b1, 16'd60);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("flush_stall_state", {30'h0, fetch_state}, 32'h1);
    chk("flush_stall_valid", {31'h0, ir_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("flush_stall_ir_pc", {16'h0, ir_pc}, 32'd60);

    // Jump word at address 26.
    step(1'b0, 1'b0, 1'b1, 16'd26);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("jump_ir_pc", {16'h0, ir_pc}, 32'd26);
    chk("jump_ir", ir, 32'h0400_0000);
    chk("jump_valid", {31'h0, ir_valid}, 32'h1);
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("jump_imem_pc", {16'h0, imem_pc}, 32'd0);
`else
    chk("jump_imem_pc", {16'h0, imem_pc}, 32'd27);
`endif
    step(1'b0, 1'b0, 1'b0, '0);

    // Reset in the middle of the stream.
    step(1'b1, 1'b0, 1'b0, '0);
    chk("mid_rst_pc", {16'h0, imem_pc}, 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("mid_rst_ir_pc", {16'h0, ir_pc}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
